// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding, parity modes and oversample divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  function automatic int os_div(input longint clk_hz, input longint baud);
    return int'((clk_hz + baud * 8) / (baud * 16));
  endfunction
endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: received-byte valid/ready handshake plus sticky line-error status
interface uart_rx_core_if;
  logic [7:0] rx_data;
  logic rx_valid, rx_ready, frame_err, parity_err, overrun, break_det, err_clr, busy;
  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun, break_det, busy,
    input rx_ready, err_clr
  );
  modport slave (
    input rx_data, rx_valid, frame_err, parity_err, overrun, break_det, busy,
    output rx_ready, err_clr
  );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-clock tick every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input logic clk,
  input logic rst_n,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampling UART receiver with valid/ready byte output and sticky line-error flags
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int OS_DIV = os_div(CLK_FREQ, BAUD)
) (
  input logic clk,
  input logic rst_n,
  input logic rxd,
  uart_rx_core_if.master bus
);
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
  rx_state_e state, state_n;
  logic s1, rxd_s, tick, armed, bit_done, maj, par_exp, start, stop_done, load;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt, smp;
  logic [7:0] data;
  uart_baud_tick #(.DIV(OS_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign bit_done = tick && os_cnt == 4'd15;
  assign maj = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign start = state == IDLE && armed && !rxd_s;
  assign stop_done = state == STOP && bit_done;
  assign load = stop_done && (!bus.rx_valid || bus.rx_ready);
  assign par_exp = PARITY == PAR_ODD ? ~^data : ^data;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? START : IDLE;
      START: state_n = !bit_done ? START : maj ? IDLE : DATA;
      DATA: state_n = !(bit_done && bit_cnt == LAST) ? DATA : PARITY != PAR_NONE ? uart_pkg::PARITY : STOP;
      uart_pkg::PARITY: state_n = bit_done ? STOP : uart_pkg::PARITY;
      STOP: state_n = bit_done ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b1;
      rxd_s <= 1'b1;
      state <= IDLE;
      armed <= 1'b0;
      os_cnt <= '0;
      bit_cnt <= '0;
      smp <= '0;
      data <= '0;
    end else begin
      s1 <= rxd;
      rxd_s <= s1;
      state <= state_n;
      // a low stop bit means the line may still be in break: wait for idle-high before re-arming
      armed <= stop_done ? maj : (state == IDLE && rxd_s) ? 1'b1 : armed;
      os_cnt <= start ? 4'd0 : tick ? os_cnt + 4'd1 : os_cnt;
      if (tick && os_cnt inside {[4'd7:4'd9]}) smp <= {rxd_s, smp[2:1]};
      if (state == START && bit_done) bit_cnt <= '0;
      else if (state == DATA && bit_done) bit_cnt <= bit_cnt + 3'd1;
      if (start) data <= '0;
      else if (state == DATA && bit_done) data[bit_cnt] <= maj;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overrun <= 1'b0;
      bus.break_det <= 1'b0;
    end else begin
      bus.rx_valid <= load || (bus.rx_valid && !bus.rx_ready);
      if (load) bus.rx_data <= data;
      bus.frame_err <= (stop_done && !maj) || (bus.frame_err && !bus.err_clr);
      bus.break_det <= (stop_done && !maj && data == 8'd0) || (bus.break_det && !bus.err_clr);
      bus.parity_err <= (state == uart_pkg::PARITY && bit_done && maj != par_exp) || (bus.parity_err && !bus.err_clr);
      bus.overrun <= (stop_done && !load) || (bus.overrun && !bus.err_clr);
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table-driven, hand-sequenced and randomized checks of the UART receiver
module tb_uart_rx_core;
  localparam int BIT = 96;
  typedef struct {
    logic [7:0] d;
    logic stop;
    logic [7:0] exp_d;
    logic exp_fe;
    logic exp_bd;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, rxd_a = 1'b1, rxd_b = 1'b1;
  int checks = 0, failures = 0;
  logic [7:0] got_a[$], got_b[$], exp_q[$];
  vec_t tbl[6];
  uart_rx_core_if bus_a ();
  uart_rx_core_if bus_b ();
  uart_rx_core #(.BAUD(1000000)) dut_a (.clk(clk), .rst_n(rst_n), .rxd(rxd_a), .bus(bus_a));
  uart_rx_core #(.BAUD(1000000), .PARITY(2)) dut_b (.clk(clk), .rst_n(rst_n), .rxd(rxd_b), .bus(bus_b));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rst_n) begin
      if (bus_a.rx_valid && bus_a.rx_ready) got_a.push_back(bus_a.rx_data);
      if (bus_b.rx_valid && bus_b.rx_ready) got_b.push_back(bus_b.rx_data);
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input bit b, input logic v, input int n);
    if (b) rxd_b = v;
    else rxd_a = v;
    repeat (n) @(posedge clk);
  endtask
  task automatic idle(input bit b, input int bits);
    drive(b, 1'b1, bits * BIT);
  endtask
  task automatic send(input bit b, input logic [7:0] d, input int pbit, input logic stop);
    drive(b, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b, d[i], BIT);
    if (pbit >= 0) drive(b, pbit[0], BIT);
    drive(b, stop, BIT);
    drive(b, 1'b1, 0);
  endtask
  task automatic clr(input bit b);
    @(posedge clk);
    if (b) bus_b.err_clr = 1'b1;
    else bus_a.err_clr = 1'b1;
    @(posedge clk);
    bus_a.err_clr = 1'b0;
    bus_b.err_clr = 1'b0;
  endtask
  task automatic pop_a(output logic [7:0] d);
    d = got_a.size() > 0 ? got_a.pop_front() : 8'hxx;
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_data"}, bus_a.rx_data, 0);
    check({tag, "_valid"}, bus_a.rx_valid, 0);
    check({tag, "_busy"}, bus_a.busy, 0);
    check({tag, "_flags"}, {bus_a.frame_err, bus_a.parity_err, bus_a.overrun, bus_a.break_det}, 0);
  endtask
  initial begin
    logic [7:0] d;
    logic bad;
    tbl = '{
      '{8'h55, 1'b1, 8'h55, 1'b0, 1'b0},
      '{8'hA3, 1'b1, 8'hA3, 1'b0, 1'b0},
      '{8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0},
      '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0},
      '{8'h81, 1'b0, 8'h81, 1'b1, 1'b0},
      '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1}
    };
    bus_a.rx_ready = 1'b1;
    bus_a.err_clr = 1'b0;
    bus_b.rx_ready = 1'b1;
    bus_b.err_clr = 1'b0;
    repeat (5) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    idle(0, 2);
    for (int i = 0; i < 6; i++) begin
      clr(0);
      got_a.delete();
      send(0, tbl[i].d, -1, tbl[i].stop);
      idle(0, 2);
      @(negedge clk);
      check($sformatf("tbl%0d_count", i), got_a.size(), 1);
      pop_a(d);
      check($sformatf("tbl%0d_data", i), d, tbl[i].exp_d);
      check($sformatf("tbl%0d_frame_err", i), bus_a.frame_err, tbl[i].exp_fe);
      check($sformatf("tbl%0d_break_det", i), bus_a.break_det, tbl[i].exp_bd);
      check($sformatf("tbl%0d_overrun", i), bus_a.overrun, 0);
    end
    clr(0);
    got_a.delete();
    bus_a.rx_ready = 1'b0;
    send(0, 8'h3C, -1, 1'b1);
    idle(0, 1);
    send(0, 8'h7E, -1, 1'b1);
    idle(0, 2);
    @(negedge clk);
    check("ovr_valid", bus_a.rx_valid, 1);
    check("ovr_data", bus_a.rx_data, 8'h3C);
    check("ovr_flag", bus_a.overrun, 1);
    check("ovr_none_taken", got_a.size(), 0);
    bus_a.rx_ready = 1'b1;
    idle(0, 2);
    @(negedge clk);
    check("ovr_count", got_a.size(), 1);
    pop_a(d);
    check("ovr_first", d, 8'h3C);
    check("ovr_valid_drop", bus_a.rx_valid, 0);
    clr(0);
    @(negedge clk);
    check("ovr_clear", bus_a.overrun, 0);
    drive(0, 1'b0, 12);
    drive(0, 1'b1, 12);
    @(negedge clk);
    check("glitch_busy_hi", bus_a.busy, 1);
    idle(0, 2);
    @(negedge clk);
    check("glitch_busy_lo", bus_a.busy, 0);
    check("glitch_no_byte", got_a.size(), 0);
    check("glitch_flags", {bus_a.frame_err, bus_a.parity_err, bus_a.overrun, bus_a.break_det}, 0);
    drive(0, 1'b0, 20 * BIT);
    idle(0, 2);
    @(negedge clk);
    check("brk_count", got_a.size(), 1);
    pop_a(d);
    check("brk_data", d, 8'h00);
    check("brk_frame_err", bus_a.frame_err, 1);
    check("brk_break_det", bus_a.break_det, 1);
    clr(0);
    send(0, 8'h41, -1, 1'b1);
    idle(0, 2);
    @(negedge clk);
    check("after_brk_count", got_a.size(), 1);
    pop_a(d);
    check("after_brk_data", d, 8'h41);
    check("after_brk_flags", {bus_a.frame_err, bus_a.break_det}, 0);
    bus_b.rx_ready = 1'b0;
    idle(1, 2);
    send(1, 8'h01, 0, 1'b1);
    idle(1, 2);
    @(negedge clk);
    check("par_valid", bus_b.rx_valid, 1);
    check("par_data", bus_b.rx_data, 8'h01);
    check("par_err", bus_b.parity_err, 1);
    check("par_frame_err", bus_b.frame_err, 0);
    bus_b.rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clr(1);
      got_b.delete();
      d = 8'($urandom);
      bad = 1'($urandom);
      send(1, d, int'((^d) ^ bad), 1'b1);
      idle(1, 2);
      @(negedge clk);
      check($sformatf("par_rnd%0d_data", i), got_b.size() > 0 ? got_b[0] : 8'hxx, d);
      check($sformatf("par_rnd%0d_err", i), bus_b.parity_err, bad);
    end
    got_a.delete();
    drive(0, 1'b0, BIT);
    drive(0, 1'b1, BIT);
    drive(0, 1'b0, BIT);
    drive(0, 1'b1, BIT / 2);
    check("mid_busy", bus_a.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    rxd_a = 1'b1;
    repeat (10) @(posedge clk);
    rst_n = 1'b1;
    idle(0, 2);
    send(0, 8'h99, -1, 1'b1);
    idle(0, 2);
    @(negedge clk);
    check("midrst_count", got_a.size(), 1);
    pop_a(d);
    check("midrst_data", d, 8'h99);
    clr(0);
    got_a.delete();
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send(0, d, -1, 1'b1);
      idle(0, $urandom_range(0, 2));
    end
    idle(0, 2);
    @(negedge clk);
    check("rnd_count", got_a.size(), exp_q.size());
    for (int i = 0; i < 24; i++) begin
      pop_a(d);
      check($sformatf("rnd%0d_data", i), d, exp_q[i]);
    end
    check("rnd_flags", {bus_a.frame_err, bus_a.parity_err, bus_a.overrun, bus_a.break_det}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
